fma_line_packer: RTL and testbench



---
 rtl/fma_pkg.sv | 10 +
 rtl/fma_line_fifo.sv | 47 ++++
 rtl/fma_line_packer.sv | 123 ++++++++++++
 tb/tb_fma_line_packer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared defaults and helpers for the FMA result line packer.
package fma_pkg;
   localparam int FMA_COUNT_DEF  = 2;
   localparam int WORD_WIDTH_DEF = 16;

   // Counter width that stays legal when a line holds a single phrase.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/fma_line_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on pop_data.
module fma_line_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             valid,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop   = pop && (count != '0);
   assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
   assign pop_data = mem[rd_ptr];
   assign valid    = (count != '0);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/fma_line_packer.sv
// Packs per-cycle FMA phrases into memory lines and queues them with a
// wrapping line address for the result-memory writer.
module fma_line_packer
   import fma_pkg::*;
#(
   parameter int FMA_COUNT  = FMA_COUNT_DEF,
   parameter int WORD_WIDTH = WORD_WIDTH_DEF,
   parameter int PHRASES    = 3,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 9,
   localparam int PHRASE_W   = FMA_COUNT * WORD_WIDTH,
   localparam int LINE_WIDTH = PHRASES * PHRASE_W
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [PHRASE_W-1:0]   fma_out,
   input  logic [FMA_COUNT-1:0]  fma_valid_out,
   output logic                  fma_ready_in,
   input  logic                  flush_in,
   output logic [LINE_WIDTH-1:0] line_out,
   output logic [ADDR_WIDTH-1:0] line_addr_out,
   output logic                  line_partial_out,
   output logic                  line_valid,
   input  logic                  line_ready,
   output logic                  overflow_out,
   input  logic                  clear_in
);
   localparam int IDX_W = idx_width(PHRASES);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic                  partial;
      logic [ADDR_WIDTH-1:0] addr;
      logic [LINE_WIDTH-1:0] data;
   } line_entry_t;

   localparam int ENTRY_W = $bits(line_entry_t);

   logic [IDX_W-1:0]      phrase_idx;
   logic [LINE_WIDTH-1:0] asm_line;
   logic [ADDR_WIDTH-1:0] line_addr;
   logic                  overflow;
   logic [CNT_W-1:0]      fifo_count;
   logic [PHRASE_W-1:0]   phrase;
   logic [LINE_WIDTH-1:0] merged;
   logic                  accept;
   logic                  drop;
   logic                  last;
   logic                  flush_eff;
   logic                  push;
   line_entry_t           push_entry;
   line_entry_t           head_entry;
   logic [ENTRY_W-1:0]    head_bits;

   assign fma_ready_in = (fifo_count < CNT_W'(DEPTH));
   assign accept       = (|fma_valid_out) && fma_ready_in;
   assign drop         = (|fma_valid_out) && !fma_ready_in;
   assign last         = accept && (phrase_idx == IDX_W'(PHRASES - 1));
   assign flush_eff    = flush_in && fma_ready_in && ((phrase_idx != '0) || accept);
   assign push         = last || flush_eff;

   always_comb begin
      phrase = '0;
      for (int i = 0; i < FMA_COUNT; i++)
         if (fma_valid_out[i]) phrase[i*WORD_WIDTH +: WORD_WIDTH] = fma_out[i*WORD_WIDTH +: WORD_WIDTH];
   end

   // Unfilled slots stay zero because the assembly register clears on every push.
   always_comb begin
      merged = asm_line;
      for (int p = 0; p < PHRASES; p++)
         if (accept && (phrase_idx == IDX_W'(p))) merged[p*PHRASE_W +: PHRASE_W] = phrase;
   end

   always_comb begin
      push_entry         = '0;
      push_entry.partial = flush_eff && !last;
      push_entry.addr    = line_addr;
      push_entry.data    = merged;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         phrase_idx <= '0;
         asm_line   <= '0;
         line_addr  <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) begin
            phrase_idx <= '0;
            asm_line   <= '0;
         end else if (accept) begin
            phrase_idx <= phrase_idx + 1'b1;
            asm_line   <= merged;
         end
         if (clear_in)  line_addr <= '0;
         else if (push) line_addr <= line_addr + 1'b1;
         // A drop in the same cycle as a clear still leaves the flag set.
         if (drop)          overflow <= 1'b1;
         else if (clear_in) overflow <= 1'b0;
      end
   end

   fma_line_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .push      (push),
      .push_data (push_entry),
      .pop       (line_ready),
      .pop_data  (head_bits),
      .valid     (line_valid),
      .count     (fifo_count)
   );

   assign head_entry       = line_entry_t'(head_bits);
   assign line_out         = head_entry.data;
   assign line_addr_out    = head_entry.addr;
   assign line_partial_out = head_entry.partial;
   assign overflow_out     = overflow;
endmodule

// File: tb/tb_fma_line_packer.sv
// Directed bench for fma_line_packer with a two-entry FIFO and 2-bit addresses.
module tb_fma_line_packer;
   logic        clk;
   logic        rst_n;
   logic [31:0] fma_data;
   logic [1:0]  fma_valid;
   logic        fma_ready;
   logic        flush;
   logic [95:0] line;
   logic [1:0]  line_addr;
   logic        line_partial;
   logic        line_valid;
   logic        line_ready;
   logic        overflow;
   logic        clear;

   int passed = 0;
   int total  = 0;

   fma_line_packer #(
      .FMA_COUNT  (2),
      .WORD_WIDTH (16),
      .PHRASES    (3),
      .DEPTH      (2),
      .ADDR_WIDTH (2)
   ) dut (
      .clk_in           (clk),
      .rst_n_in         (rst_n),
      .fma_out          (fma_data),
      .fma_valid_out    (fma_valid),
      .fma_ready_in     (fma_ready),
      .flush_in         (flush),
      .line_out         (line),
      .line_addr_out    (line_addr),
      .line_partial_out (line_partial),
      .line_valid       (line_valid),
      .line_ready       (line_ready),
      .overflow_out     (overflow),
      .clear_in         (clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic phrase(input logic [15:0] l1, input logic [15:0] l0, input logic [1:0] v);
      fma_data  = {l1, l0};
      fma_valid = v;
      tick();
      fma_valid = 2'b00;
   endtask

   logic [1:0] wrap_addr [5];

   initial begin
      wrap_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rst_n = 1'b0; fma_data = '0; fma_valid = '0; flush = 0;
      line_ready = 0; clear = 0;
      #12;
      chk("rst_valid", line_valid, 0);
      chk("rst_line", line, 0);
      chk("rst_addr", line_addr, 0);
      chk("rst_partial", line_partial, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_ready", fma_ready, 1);
      rst_n = 1'b1;
      tick();

      // full line
      phrase(16'h0002, 16'h0001, 2'b11);
      chk("full_p1_valid", line_valid, 0);
      phrase(16'h0004, 16'h0003, 2'b11);
      chk("full_p2_valid", line_valid, 0);
      phrase(16'h0006, 16'h0005, 2'b11);
      chk("full_valid", line_valid, 1);
      chk("full_line", line, 96'h0006_0005_0004_0003_0002_0001);
      chk("full_addr", line_addr, 0);
      chk("full_partial", line_partial, 0);
      tick();
      chk("full_stable", line, 96'h0006_0005_0004_0003_0002_0001);
      line_ready = 1; tick(); line_ready = 0;
      chk("full_popped", line_valid, 0);

      // partial flush
      phrase(16'hBBBB, 16'hAAAA, 2'b11);
      flush = 1; tick(); flush = 0;
      chk("flush_valid", line_valid, 1);
      chk("flush_line", line, 96'h0000_0000_0000_0000_BBBB_AAAA);
      chk("flush_partial", line_partial, 1);
      chk("flush_addr", line_addr, 1);
      line_ready = 1; tick(); line_ready = 0;
      flush = 1; tick(); flush = 0;
      chk("flush_noop", line_valid, 0);

      // masked lane with flush in the same cycle
      flush = 1;
      phrase(16'hFFFF, 16'h1234, 2'b01);
      flush = 0;
      chk("mask_valid", line_valid, 1);
      chk("mask_line", line, 96'h0000_0000_0000_0000_0000_1234);
      chk("mask_addr", line_addr, 2);
      line_ready = 1; tick(); line_ready = 0;

      clear = 1; tick(); clear = 0;

      // backpressure: nine phrases into a two-line FIFO
      for (int k = 1; k <= 9; k++) begin
         phrase(16'h0200 + 16'(k), 16'h0100 + 16'(k), 2'b11);
         if (k == 5) chk("bp_ready_5", fma_ready, 1);
         if (k == 6) chk("bp_ready_6", fma_ready, 0);
         if (k == 6) chk("bp_ovf_6", overflow, 0);
         if (k == 7) chk("bp_ovf_7", overflow, 1);
      end
      chk("bp_head_line", line, 96'h0203_0103_0202_0102_0201_0101);
      chk("bp_head_addr", line_addr, 0);
      line_ready = 1; tick();
      chk("bp_second_valid", line_valid, 1);
      chk("bp_second_line", line, 96'h0206_0106_0205_0105_0204_0104);
      chk("bp_second_addr", line_addr, 1);
      chk("bp_ready_back", fma_ready, 1);
      tick();
      chk("bp_empty", line_valid, 0);
      chk("bp_ovf_sticky", overflow, 1);

      clear = 1; tick(); clear = 0;
      chk("clear_ovf", overflow, 0);

      // address wrap over five lines with line_ready held high
      for (int j = 0; j < 5; j++) begin
         for (int q = 0; q < 3; q++)
            phrase(16'h2000 + 16'(j*16 + q), 16'h1000 + 16'(j*16 + q), 2'b11);
         chk("wrap_valid", line_valid, 1);
         chk("wrap_addr", line_addr, wrap_addr[j]);
         chk("wrap_partial", line_partial, 0);
      end
      line_ready = 0;
      for (int q = 0; q < 6; q++) phrase(16'h3333, 16'h4444, 2'b11);
      chk("wrap_ovf", overflow, 1);
      line_ready = 1; tick(); tick(); line_ready = 0;
      chk("wrap_drained", line_valid, 0);
      clear = 1; tick(); clear = 0;
      chk("wrap_clear_ovf", overflow, 0);
      phrase(16'h0C02, 16'h0C01, 2'b11);
      phrase(16'h0C04, 16'h0C03, 2'b11);
      phrase(16'h0C06, 16'h0C05, 2'b11);
      chk("wrap_clear_addr", line_addr, 0);
      chk("wrap_clear_line", line, 96'h0C06_0C05_0C04_0C03_0C02_0C01);
      line_ready = 1; tick(); line_ready = 0;

      // reset in the middle of a line
      phrase(16'hDEAD, 16'hBEEF, 2'b11);
      phrase(16'hDEAD, 16'hBEEF, 2'b11);
      rst_n = 0;
      #1;
      chk("mid_rst_valid", line_valid, 0);
      chk("mid_rst_ready", fma_ready, 1);
      tick();
      rst_n = 1;
      phrase(16'h0A02, 16'h0A01, 2'b11);
      chk("mid_p1_valid", line_valid, 0);
      phrase(16'h0A04, 16'h0A03, 2'b11);
      chk("mid_p2_valid", line_valid, 0);
      phrase(16'h0A06, 16'h0A05, 2'b11);
      chk("mid_valid", line_valid, 1);
      chk("mid_addr", line_addr, 0);
      chk("mid_line", line, 96'h0A06_0A05_0A04_0A03_0A02_0A01);
      chk("mid_partial", line_partial, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
